io_device_port: RTL and testbench

Device-side endpoint for the processor's memory-mapped I/O word. Consumes the 16-bit `ioOutput` driven by the memory/IO stage and produces the 16-bit `ioInput` it reads back. Converts the CPU's toggle-flag protocol into valid/ready byte streams toward an external device. TX bytes pass through a small FIFO; RX bytes are held in a single presentation register.

---
 rtl/io_port_pkg.sv | 21 ++
 rtl/io_byte_fifo.sv | 60 ++++++
 rtl/io_device_port.sv | 129 ++++++++++++
 tb/tb_io_device_port.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// Shared constants and types for the I/O device port: bit positions in the CPU
// words, the RX presentation-register state, and the ioInput reset image.
package io_port_pkg;

    // Positions in ioOutput (CPU write) and ioInput (CPU read); 15/14 are the toggles in both.
    localparam int TX_TOG    = 15;
    localparam int ACK_TOG   = 14;
    localparam int LOOP      = 13;
    localparam int FULL      = 13;
    localparam int EMPTY     = 12;
    localparam int COUNT_MSB = 11;
    localparam int COUNT_LSB = 8;

    typedef enum logic {
        RX_EMPTY,
        RX_FULL
    } rx_state_e;

    localparam logic [15:0] IOIN_RESET = 16'h1000;

endpackage

// File: rtl/io_byte_fifo.sv
// Show-ahead byte FIFO: head byte is visible whenever the FIFO is non-empty.
// DEPTH must be a power of two (2..8) so the pointers wrap naturally.
module io_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic [3:0] o_count,
    output logic       o_full,
    output logic       o_empty
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [3:0]    r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // A pop in the same cycle frees the slot the push needs.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: the byte storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == 4'd0);

endmodule

// File: rtl/io_device_port.sv
// Device-side endpoint for the CPU's memory-mapped I/O word: toggle-flag CPU
// protocol to valid/ready byte streams. Optional loopback: IO_DEVICE_PORT_LOOPBACK_EN.
module io_device_port
    import io_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] ioOutput,
    output logic [15:0] ioInput,
    output logic [7:0]  dev_tx_data,
    output logic        dev_tx_valid,
    input  logic        dev_tx_ready,
    input  logic [7:0]  dev_rx_data,
    input  logic        dev_rx_valid,
    output logic        dev_rx_ready
);

    logic [15:0] r_io_q;
    logic        r_tx_seen;
    logic        r_tx_ack;
    logic        r_rx_seen;
    logic        r_rx_tog;
    logic [7:0]  r_rx_byte;
    rx_state_e   r_rx_state;

    logic        w_loop;
    logic        w_tx_pending;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_rx_load;
    logic [7:0]  w_rx_byte_in;
    logic [7:0]  w_head;
    logic [3:0]  w_count;
    logic        w_full;
    logic        w_empty;
    logic [15:0] w_io_in;
    logic        w_unused_io;

    always_ff @(posedge CLK) begin
        if (!reset) r_io_q <= '0;
        else        r_io_q <= ioOutput;
    end

    assign w_unused_io = ^r_io_q[LOOP:COUNT_LSB];

`ifdef IO_DEVICE_PORT_LOOPBACK_EN
    // In loopback the FIFO head feeds the RX register whenever it is free.
    assign w_loop       = r_io_q[LOOP];
    assign w_tx_pop     = reset && !w_empty && (w_loop ? (r_rx_state == RX_EMPTY) : dev_tx_ready);
    assign w_rx_load    = w_loop ? w_tx_pop : dev_rx_valid;
    assign w_rx_byte_in = w_loop ? w_head : dev_rx_data;
`else
    assign w_loop       = 1'b0;
    assign w_tx_pop     = reset && !w_empty && dev_tx_ready;
    assign w_rx_load    = dev_rx_valid;
    assign w_rx_byte_in = dev_rx_data;
`endif

    assign w_tx_pending = (r_io_q[TX_TOG] != r_tx_seen);
    assign w_tx_push    = reset && w_tx_pending && (!w_full || w_tx_pop);

    io_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk         (CLK),
        .rst_n       (reset),
        .i_push      (w_tx_push),
        .i_push_data (r_io_q[7:0]),
        .i_pop       (w_tx_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // A withheld capture leaves tx_seen stale, so the toggle stays pending until space frees.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_tx_seen <= 1'b0;
            r_tx_ack  <= IOIN_RESET[ACK_TOG];
        end else if (w_tx_push) begin
            r_tx_seen <= r_io_q[TX_TOG];
            r_tx_ack  <= ~r_tx_ack;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_rx_state <= RX_EMPTY;
            r_rx_seen  <= 1'b0;
            r_rx_tog   <= IOIN_RESET[TX_TOG];
            r_rx_byte  <= IOIN_RESET[7:0];
        end else begin
            unique case (r_rx_state)
                RX_EMPTY: begin
                    if (w_rx_load) begin
                        r_rx_byte  <= w_rx_byte_in;
                        r_rx_tog   <= ~r_rx_tog;
                        r_rx_state <= RX_FULL;
                    end
                end
                RX_FULL: begin
                    if (r_io_q[ACK_TOG] != r_rx_seen) begin
                        r_rx_seen  <= r_io_q[ACK_TOG];
                        r_rx_state <= RX_EMPTY;
                    end
                end
                default: r_rx_state <= RX_EMPTY;
            endcase
        end
    end

    // NOTE: give every combinational output a default first so no path infers a latch.
    always_comb begin
        w_io_in                      = '0;
        w_io_in[TX_TOG]              = r_rx_tog;
        w_io_in[ACK_TOG]             = r_tx_ack;
        w_io_in[FULL]                = w_full;
        w_io_in[EMPTY]               = w_empty;
        w_io_in[COUNT_MSB:COUNT_LSB] = w_count;
        w_io_in[7:0]                 = r_rx_byte;
    end

    assign ioInput      = w_io_in;
    assign dev_tx_data  = w_head;
    assign dev_tx_valid = reset && !w_empty && !w_loop;
    assign dev_rx_ready = reset && (r_rx_state == RX_EMPTY) && !w_loop;

endmodule

// File: tb/tb_io_device_port.sv
// Directed self-checking bench for io_device_port (DEPTH = 4); the loopback
// scenario is compiled in only when IO_DEVICE_PORT_LOOPBACK_EN is defined.
module tb_io_device_port;

    logic        CLK;
    logic        reset;
    logic [15:0] ioOutput;
    logic [15:0] ioInput;
    logic [7:0]  dev_tx_data;
    logic        dev_tx_valid;
    logic        dev_tx_ready;
    logic [7:0]  dev_rx_data;
    logic        dev_rx_valid;
    logic        dev_rx_ready;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic tx_tog, ack_tog, exp_ack, exp_rx_tog;

    io_device_port #(.DEPTH(4)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .ioOutput     (ioOutput),
        .ioInput      (ioInput),
        .dev_tx_data  (dev_tx_data),
        .dev_tx_valid (dev_tx_valid),
        .dev_tx_ready (dev_tx_ready),
        .dev_rx_data  (dev_rx_data),
        .dev_rx_valid (dev_rx_valid),
        .dev_rx_ready (dev_rx_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_io(input logic [7:0] b, input logic lp);
        ioOutput = {tx_tog, ack_tog, lp, 5'b0, b};
    endtask

    // One CPU write: flip the TX toggle, then allow io_q capture plus push.
    task automatic cpu_write(input logic [7:0] b);
        tx_tog = ~tx_tog;
        drive_io(b, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; ioOutput = '0; dev_tx_ready = 1'b0;
        dev_rx_valid = 1'b0; dev_rx_data = '0;
        tx_tog = 1'b0; ack_tog = 1'b0; exp_ack = 1'b0; exp_rx_tog = 1'b0;
        tick(); tick();
        n_checks++; if (dev_rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready_low: got %b expected 0", dev_rx_ready); end
        n_checks++; if (ioInput !== 16'h1000) begin n_fail++; $display("FAIL rst_ioin: got %h expected 1000", ioInput); end
        n_checks++; if (dev_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b expected 0", dev_tx_valid); end
        reset = 1'b1;
        #1;
        n_checks++; if (dev_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready_rel: got %b expected 1", dev_rx_ready); end
        tick();
        n_checks++; if (ioInput !== 16'h1000) begin n_fail++; $display("FAIL rst_ioin_idle: got %h expected 1000", ioInput); end
    endtask

    task automatic test_single_tx();
        tx_tog = 1'b1;
        drive_io(8'h41, 1'b0);
        tick();
        n_checks++; if (ioInput[14] !== 1'b0) begin n_fail++; $display("FAIL tx_ack_early: got %b expected 0", ioInput[14]); end
        tick();
        exp_ack = 1'b1;
        n_checks++; if (ioInput[14] !== exp_ack) begin n_fail++; $display("FAIL tx_ack: got %b expected %b", ioInput[14], exp_ack); end
        n_checks++; if (dev_tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_valid: got %b expected 1", dev_tx_valid); end
        n_checks++; if (dev_tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_data: got %h expected 41", dev_tx_data); end
        n_checks++; if (ioInput[12] !== 1'b0) begin n_fail++; $display("FAIL tx_empty_clr: got %b expected 0", ioInput[12]); end
        dev_tx_ready = 1'b1;
        tick();
        dev_tx_ready = 1'b0;
        n_checks++; if (ioInput[12] !== 1'b1) begin n_fail++; $display("FAIL tx_empty_set: got %b expected 1", ioInput[12]); end
        n_checks++; if (dev_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_valid_drop: got %b expected 0", dev_tx_valid); end
    endtask

    task automatic test_backpressure();
        for (int i = 1; i <= 4; i++) begin
            cpu_write(8'(i));
            exp_ack = ~exp_ack;
            n_checks++; if (ioInput[14] !== exp_ack) begin n_fail++; $display("FAIL bp_ack_%0d: got %b expected %b", i, ioInput[14], exp_ack); end
        end
        n_checks++; if (ioInput[11:8] !== 4'd4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", ioInput[11:8]); end
        n_checks++; if (ioInput[13] !== 1'b1) begin n_fail++; $display("FAIL bp_full: got %b expected 1", ioInput[13]); end
        cpu_write(8'h05);
        tick();
        n_checks++; if (ioInput[14] !== exp_ack) begin n_fail++; $display("FAIL bp_ack_withheld: got %b expected %b", ioInput[14], exp_ack); end
        n_checks++; if (dev_tx_data !== 8'h01) begin n_fail++; $display("FAIL bp_head_1: got %h expected 01", dev_tx_data); end
        dev_tx_ready = 1'b1;
        tick();
        dev_tx_ready = 1'b0;
        exp_ack = ~exp_ack;
        n_checks++; if (ioInput[14] !== exp_ack) begin n_fail++; $display("FAIL bp_ack_late: got %b expected %b", ioInput[14], exp_ack); end
        n_checks++; if (ioInput[11:8] !== 4'd4) begin n_fail++; $display("FAIL bp_count_after_pop: got %0d expected 4", ioInput[11:8]); end
        dev_tx_ready = 1'b1;
        for (int b = 2; b <= 5; b++) begin
            n_checks++; if (dev_tx_valid !== 1'b1 || dev_tx_data !== 8'(b)) begin n_fail++; $display("FAIL bp_drain_%0d: got v=%b d=%h expected v=1 d=%h", b, dev_tx_valid, dev_tx_data, 8'(b)); end
            tick();
        end
        dev_tx_ready = 1'b0;
        n_checks++; if (ioInput[12] !== 1'b1) begin n_fail++; $display("FAIL bp_drained_empty: got %b expected 1", ioInput[12]); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            cpu_write(8'h11 + 8'(i));
            exp_ack = ~exp_ack;
        end
        tx_tog = ~tx_tog;
        drive_io(8'h15, 1'b0);
        tick();
        dev_tx_ready = 1'b1;
        tick();
        dev_tx_ready = 1'b0;
        exp_ack = ~exp_ack;
        n_checks++; if (ioInput[14] !== exp_ack) begin n_fail++; $display("FAIL sim_ack: got %b expected %b", ioInput[14], exp_ack); end
        n_checks++; if (ioInput[11:8] !== 4'd4 || ioInput[13] !== 1'b1) begin n_fail++; $display("FAIL sim_count: got %0d full=%b expected 4 full=1", ioInput[11:8], ioInput[13]); end
        dev_tx_ready = 1'b1;
        for (int b = 8'h12; b <= 8'h15; b++) begin
            n_checks++; if (dev_tx_valid !== 1'b1 || dev_tx_data !== 8'(b)) begin n_fail++; $display("FAIL sim_drain_%h: got v=%b d=%h expected v=1 d=%h", 8'(b), dev_tx_valid, dev_tx_data, 8'(b)); end
            tick();
        end
        dev_tx_ready = 1'b0;
        n_checks++; if (dev_tx_valid !== 1'b0) begin n_fail++; $display("FAIL sim_empty: got %b expected 0", dev_tx_valid); end
    endtask

    task automatic test_rx();
        dev_rx_data = 8'hA5; dev_rx_valid = 1'b1;
        n_checks++; if (dev_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_idle: got %b expected 1", dev_rx_ready); end
        tick();
        dev_rx_data = 8'h5A;
        exp_rx_tog = ~exp_rx_tog;
        n_checks++; if (ioInput !== {exp_rx_tog, exp_ack, 2'b01, 4'h0, 8'hA5}) begin n_fail++; $display("FAIL rx_ioin: got %h expected %h", ioInput, {exp_rx_tog, exp_ack, 2'b01, 4'h0, 8'hA5}); end
        n_checks++; if (dev_rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_full: got %b expected 0", dev_rx_ready); end
        tick();
        dev_rx_valid = 1'b0;
        n_checks++; if (ioInput[15] !== exp_rx_tog || ioInput[7:0] !== 8'hA5) begin n_fail++; $display("FAIL rx_second_ignored: got tog=%b byte=%h expected tog=%b byte=a5", ioInput[15], ioInput[7:0], exp_rx_tog); end
        ack_tog = ~ack_tog;
        drive_io(8'h00, 1'b0);
        tick();
        n_checks++; if (dev_rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_ack_early: got %b expected 0", dev_rx_ready); end
        tick();
        n_checks++; if (dev_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_ack: got %b expected 1", dev_rx_ready); end
        dev_rx_data = 8'h3C; dev_rx_valid = 1'b1;
        tick();
        dev_rx_valid = 1'b0;
        exp_rx_tog = ~exp_rx_tog;
        n_checks++; if (ioInput[15] !== exp_rx_tog || ioInput[7:0] !== 8'h3C) begin n_fail++; $display("FAIL rx_second_byte: got tog=%b byte=%h expected tog=%b byte=3c", ioInput[15], ioInput[7:0], exp_rx_tog); end
        ack_tog = ~ack_tog;
        drive_io(8'h00, 1'b0);
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            cpu_write(8'h21 + 8'(i));
            exp_ack = ~exp_ack;
        end
        dev_rx_data = 8'h77; dev_rx_valid = 1'b1;
        tick();
        dev_rx_valid = 1'b0;
        n_checks++; if (ioInput[11:8] !== 4'd3 || dev_rx_ready !== 1'b0) begin n_fail++; $display("FAIL rm_setup: got count=%0d rdy=%b expected count=3 rdy=0", ioInput[11:8], dev_rx_ready); end
        reset = 1'b0; ioOutput = '0; tx_tog = 1'b0; ack_tog = 1'b0;
        dev_rx_valid = 1'b1; dev_tx_ready = 1'b1;
        #1;
        n_checks++; if (dev_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rm_tx_valid_in_reset: got %b expected 0", dev_tx_valid); end
        tick();
        reset = 1'b1; dev_rx_valid = 1'b0; dev_tx_ready = 1'b0;
        exp_ack = 1'b0; exp_rx_tog = 1'b0;
        #1;
        n_checks++; if (ioInput !== 16'h1000) begin n_fail++; $display("FAIL rm_ioin: got %h expected 1000", ioInput); end
        n_checks++; if (dev_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rm_tx_valid: got %b expected 0", dev_tx_valid); end
        n_checks++; if (dev_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rm_rx_ready: got %b expected 1", dev_rx_ready); end
        tick(); tick();
        n_checks++; if (ioInput !== 16'h1000) begin n_fail++; $display("FAIL rm_ioin_settled: got %h expected 1000", ioInput); end
    endtask

`ifdef IO_DEVICE_PORT_LOOPBACK_EN
    task automatic test_loopback();
        tx_tog = 1'b1;
        drive_io(8'h33, 1'b1);
        tick(); tick();
        n_checks++; if (dev_tx_valid !== 1'b0 || ioInput[11:8] !== 4'd1) begin n_fail++; $display("FAIL lb_pushed: got v=%b count=%0d expected v=0 count=1", dev_tx_valid, ioInput[11:8]); end
        tick();
        n_checks++; if (ioInput !== 16'hD033) begin n_fail++; $display("FAIL lb_ioin: got %h expected d033", ioInput); end
        n_checks++; if (dev_tx_valid !== 1'b0 || dev_rx_ready !== 1'b0) begin n_fail++; $display("FAIL lb_dev_side: got v=%b rdy=%b expected 0 0", dev_tx_valid, dev_rx_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_tx();
        test_backpressure();
        test_simultaneous();
        test_rx();
        test_reset_mid();
`ifdef IO_DEVICE_PORT_LOOPBACK_EN
        test_loopback();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
